// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: byte tables, GF(2^8) helpers, inverse-round
// transforms and the FSM state type used by the iterative decryptor.
package aes_pkg;

   localparam int         NK      = 4;
   localparam int         BLOCK_W = 32 * NK;
   localparam logic [3:0] NR      = 4'd10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      KEXP  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } aes_state_e;

   typedef enum logic {
      KEY_FWD = 1'b0,
      KEY_BWD = 1'b1
   } key_dir_e;

   // Byte 0x00 sits in the most significant byte of each table.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b000};
      return SBOX_TBL[idx +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b000};
      return INV_SBOX_TBL[idx +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] r;
      case (i)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [7:0] mul11(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic logic [7:0] mul13(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic logic [7:0] mul14(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Column-major state: byte (row r, column c) is byte index 4c+r from the MSB.
   function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] o;
      int                 src;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = (c - r + 4) % 4;
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      end
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
              mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
              mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
              mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
   endfunction

   function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
      logic [BLOCK_W-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
      end
      return o;
   endfunction

   function automatic logic [BLOCK_W-1:0] add_round_key(input logic [BLOCK_W-1:0] s,
                                                         input logic [BLOCK_W-1:0] k);
      return s ^ k;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (rk(i-1) -> rk(i)) or backward
// (rk(i) -> rk(i-1)); a single SubWord is shared by both directions.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [BLOCK_W-1:0] rk_i,
   input  logic [7:0]         rcon_i,
   input  key_dir_e           dir_i,
   output logic [BLOCK_W-1:0] rk_o
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] sw_in, t;
   logic [31:0] f0, f1, f2, f3;

   assign {w0, w1, w2, w3} = rk_i;

   // Going backward, the word that fed SubWord is recovered as w3^w2.
   assign sw_in = (dir_i == KEY_FWD) ? w3 : (w3 ^ w2);
   assign t     = sub_word(rot_word(sw_in)) ^ {rcon_i, 24'h000000};

   assign f0 = w0 ^ t;
   assign f1 = w1 ^ f0;
   assign f2 = w2 ^ f1;
   assign f3 = w3 ^ f2;

   always_comb begin
      rk_o = {f0, f1, f2, f3};
      if (dir_i == KEY_BWD) begin
         rk_o = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
      end
   end

endmodule

// File: rtl/aes_decrypt_top_module.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys derived
// on the fly, with an optional cache of the last expanded round key 10.
module aes_decrypt_top_module
   import aes_pkg::*;
#(
   parameter bit KEY_CACHE_EN = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [BLOCK_W-1:0] cipher_text,
   input  logic [BLOCK_W-1:0] cipher_key,
   input  logic               plain_new_en,
   output logic [BLOCK_W-1:0] plain_text,
   output logic               plain_ready,
   output logic               busy
);

   // Handshake: a start (plain_new_en) is taken on any edge where busy=0 and
   // captures cipher_text/cipher_key; busy then stays high until the edge that
   // raises plain_ready, which holds with plain_text until the next start.

   aes_state_e         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [BLOCK_W-1:0] data_q, data_d;
   logic [BLOCK_W-1:0] rk_q, rk_d;
   logic [BLOCK_W-1:0] ct_q, ct_d;
   logic [BLOCK_W-1:0] key_q, key_d;
   logic [BLOCK_W-1:0] pt_q, pt_d;
   logic               cache_valid_q, cache_valid_d;
   logic [BLOCK_W-1:0] cache_key_q, cache_key_d;
   logic [BLOCK_W-1:0] cache_rk_q, cache_rk_d;

   logic [BLOCK_W-1:0] step_rk;
   logic [BLOCK_W-1:0] ark;
   logic [BLOCK_W-1:0] round_out;
   key_dir_e           step_dir;
   logic               cache_hit;

   assign step_dir = (state_q == KEXP) ? KEY_FWD : KEY_BWD;

   aes_key_step u_key_step (
      .rk_i   (rk_q),
      .rcon_i (rcon(cnt_q)),
      .dir_i  (step_dir),
      .rk_o   (step_rk)
   );

   // cnt_q == 1 is the final round, which skips InvMixColumns.
   assign ark       = add_round_key(inv_sub_bytes(inv_shift_rows(data_q)), step_rk);
   assign round_out = (cnt_q == 4'd1) ? ark : inv_mix_columns(ark);

   assign cache_hit = KEY_CACHE_EN && cache_valid_q && (cipher_key == cache_key_q);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      data_d        = data_q;
      rk_d          = rk_q;
      ct_d          = ct_q;
      key_d         = key_q;
      pt_d          = pt_q;
      cache_valid_d = cache_valid_q;
      cache_key_d   = cache_key_q;
      cache_rk_d    = cache_rk_q;

      case (state_q)
         IDLE, DONE: begin
            if (plain_new_en) begin
               ct_d  = cipher_text;
               key_d = cipher_key;
               rk_d  = cipher_key;
               if (cache_hit) begin
                  rk_d    = cache_rk_q;
                  data_d  = add_round_key(cipher_text, cache_rk_q);
                  cnt_d   = NR;
                  state_d = ROUND;
               end else begin
                  cnt_d   = 4'd1;
                  state_d = KEXP;
               end
            end
         end
         KEXP: begin
            rk_d = step_rk;
            if (cnt_q == NR) begin
               cache_valid_d = 1'b1;
               cache_key_d   = key_q;
               cache_rk_d    = step_rk;
               data_d        = add_round_key(ct_q, step_rk);
               state_d       = ROUND;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ROUND: begin
            rk_d   = step_rk;
            data_d = round_out;
            if (cnt_q == 4'd1) begin
               pt_d    = round_out;
               cnt_d   = 4'd0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         data_q        <= '0;
         rk_q          <= '0;
         ct_q          <= '0;
         key_q         <= '0;
         pt_q          <= '0;
         cache_valid_q <= 1'b0;
         cache_key_q   <= '0;
         cache_rk_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         data_q        <= data_d;
         rk_q          <= rk_d;
         ct_q          <= ct_d;
         key_q         <= key_d;
         pt_q          <= pt_d;
         cache_valid_q <= cache_valid_d;
         cache_key_q   <= cache_key_d;
         cache_rk_q    <= cache_rk_d;
      end
   end

   assign plain_text  = pt_q;
   assign plain_ready = (state_q == DONE);
   assign busy        = (state_q == KEXP) || (state_q == ROUND);

endmodule

// File: tb/tb_aes_decrypt_top_module.sv
// Directed bench for the AES-128 decryptor: a cached build and an uncached
// build share the stimulus; latencies and plaintexts come from known vectors.
module tb_aes_decrypt_top_module;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] S_KEY  = 128'h0f1571c947d9e8590cb7add6af7f6798;
   localparam logic [127:0] S_CT   = 128'hff0b844a0853bf7c6934ab4364148fb9;
   localparam logic [127:0] S_PT   = 128'h0123456789abcdeffedcba9876543210;
   localparam int COLD = 21;
   localparam int WARM = 11;

   logic         clk = 1'b0;
   logic         reset;
   logic [127:0] cipher_text;
   logic [127:0] cipher_key;
   logic         plain_new_en;
   logic [127:0] plain_text, plain_text_nc;
   logic         plain_ready, plain_ready_nc;
   logic         busy, busy_nc;

   int           vectors = 0;
   int           miscompares = 0;
   logic [127:0] last_pt;

   always #5 clk = ~clk;

   aes_decrypt_top_module #(.KEY_CACHE_EN(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .cipher_text  (cipher_text),
      .cipher_key   (cipher_key),
      .plain_new_en (plain_new_en),
      .plain_text   (plain_text),
      .plain_ready  (plain_ready),
      .busy         (busy)
   );

   aes_decrypt_top_module #(.KEY_CACHE_EN(1'b0)) dut_nc (
      .clk          (clk),
      .reset        (reset),
      .cipher_text  (cipher_text),
      .cipher_key   (cipher_key),
      .plain_new_en (plain_new_en),
      .plain_text   (plain_text_nc),
      .plain_ready  (plain_ready_nc),
      .busy         (busy_nc)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check_idle_outputs(input string tag, input logic [127:0] exp_pt);
      check({tag, " ready"},    {127'd0, plain_ready},    128'd0);
      check({tag, " busy"},     {127'd0, busy},           128'd0);
      check({tag, " pt"},       plain_text,               exp_pt);
      check({tag, " ready_nc"}, {127'd0, plain_ready_nc}, 128'd0);
      check({tag, " busy_nc"},  {127'd0, busy_nc},        128'd0);
      check({tag, " pt_nc"},    plain_text_nc,            exp_pt);
   endtask

   // Start one block, scramble the inputs right after acceptance, optionally
   // pulse a second start while busy, then wait for both builds to finish.
   task automatic run_op(input string tag, input logic [127:0] ct, input logic [127:0] key,
                         input logic [127:0] exp_pt, input int exp_lat, input int pulse_at);
      int lat_m;
      int lat_n;
      @(negedge clk);
      cipher_text  = ct;
      cipher_key   = key;
      plain_new_en = 1'b1;
      @(posedge clk);
      #1;
      plain_new_en = 1'b0;
      cipher_text  = rand128();
      cipher_key   = rand128();
      check({tag, " t1 ready"},   {127'd0, plain_ready},    128'd0);
      check({tag, " t1 busy"},    {127'd0, busy},           128'd1);
      check({tag, " t1 hold pt"}, plain_text,               last_pt);
      check({tag, " t1 busy_nc"}, {127'd0, busy_nc},        128'd1);
      lat_m = 0;
      lat_n = 0;
      for (int lat = 1; lat <= 40; lat++) begin
         if (lat_m == 0 && plain_ready) lat_m = lat;
         if (lat_n == 0 && plain_ready_nc) lat_n = lat;
         if (lat_m != 0 && lat_n != 0) break;
         plain_new_en = (lat == pulse_at);
         if (lat == pulse_at) begin
            cipher_text = rand128();
            cipher_key  = rand128();
         end
         @(posedge clk);
         #1;
      end
      plain_new_en = 1'b0;
      check({tag, " latency"},    128'(lat_m),      128'(exp_lat));
      check({tag, " latency_nc"}, 128'(lat_n),      128'(COLD));
      check({tag, " pt"},         plain_text,       exp_pt);
      check({tag, " pt_nc"},      plain_text_nc,    exp_pt);
      check({tag, " busy done"},  {127'd0, busy},   128'd0);
      check({tag, " ready held"}, {127'd0, plain_ready}, 128'd1);
      last_pt = exp_pt;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      plain_new_en = 1'b0;
      cipher_text  = '0;
      cipher_key   = '0;
      last_pt      = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset", 128'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("c1_cold",  C1_CT, C1_KEY, C1_PT, COLD, 0);
      run_op("c1_warm",  C1_CT, C1_KEY, C1_PT, WARM, 0);
      run_op("b_cold_pulse", B_CT, B_KEY, B_PT, COLD, 5);
      run_op("b_warm",   B_CT, B_KEY, B_PT, WARM, 0);
      run_op("s_cold",   S_CT, S_KEY, S_PT, COLD, 0);

      @(negedge clk);
      cipher_text  = B_CT;
      cipher_key   = B_KEY;
      plain_new_en = 1'b1;
      @(posedge clk);
      #1;
      plain_new_en = 1'b0;
      for (int lat = 1; lat < 8; lat++) @(posedge clk);
      #1;
      check("abort pre busy", {127'd0, busy}, 128'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_idle_outputs("abort", 128'd0);
      last_pt = '0;

      run_op("s_after_reset", S_CT, S_KEY, S_PT, COLD, 0);
      run_op("s_warm",        S_CT, S_KEY, S_PT, WARM, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
